// File: rtl/spi_pixel_master.sv
// rtl/spi_pixel_master.sv - Mode-0 SPI master streaming pixel frames and returning MISO bytes
module spi_pixel_master #(
    parameter int CLKDIV    = 4,
    parameter int FRAME_LEN = 784,
    parameter int PP        = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    input  logic          i_tx_valid,
    input  logic [PP-1:0] i_tx_data,
    output logic          o_tx_ready,
    output logic          o_rx_valid,
    output logic [PP-1:0] o_rx_data,
    output logic          o_sck,
    output logic          o_mosi,
    input  logic          i_miso,
    output logic          o_ssel
);

    localparam int DIV_W = $clog2(CLKDIV + 1);
    localparam int BIT_W = $clog2(PP);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKDIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PP - 1);
    localparam logic [15:0]      LAST_BYTE = 16'(FRAME_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_HIGH  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_DEASS = 3'd6;
    localparam logic [2:0] S_ABORT = 3'd7;

    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [15:0]      r_byte_cnt;
    logic [PP-1:0]    r_tx_shift;
    logic [PP-1:0]    r_rx_shift;
    logic [PP-1:0]    r_rx_data;
    logic             r_rx_valid;
    logic             r_done;
    logic             r_busy;
    logic             r_sck;
    logic             r_ssel;
    logic             r_miso_s1;
    logic             r_miso_s2;
    logic             w_div_end;

    assign w_div_end  = (r_div == DIV_LAST);
    assign o_tx_ready = (r_state == S_LOAD);
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_sck      = r_sck;
    assign o_ssel     = r_ssel;
    // MOSI is the shift register MSB, so it only moves on load or on the SCK fall
    assign o_mosi     = r_tx_shift[PP-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= i_miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_sck      <= 1'b0;
            r_ssel     <= 1'b1;
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            if (i_abort && (r_state != S_IDLE)) begin
                r_state <= S_ABORT;
                r_sck   <= 1'b0;
                r_ssel  <= 1'b1;
                r_div   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state    <= S_SETUP;
                            r_busy     <= 1'b1;
                            r_ssel     <= 1'b0;
                            r_byte_cnt <= '0;
                            r_div      <= '0;
                        end
                    end
                    S_SETUP: begin
                        if (w_div_end) begin
                            r_state <= S_LOAD;
                            r_div   <= '0;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    S_LOAD: begin
                        if (i_tx_valid) begin
                            r_tx_shift <= i_tx_data;
                            r_bit_cnt  <= '0;
                            r_div      <= '0;
                            r_state    <= S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (w_div_end) begin
                            r_state    <= S_HIGH;
                            r_sck      <= 1'b1;
                            r_div      <= '0;
                            r_rx_shift <= {r_rx_shift[PP-2:0], r_miso_s2};
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    S_HIGH: begin
                        if (w_div_end) begin
                            r_sck <= 1'b0;
                            r_div <= '0;
                            if (r_bit_cnt != BIT_LAST) begin
                                r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                                r_tx_shift <= {r_tx_shift[PP-2:0], 1'b0};
                                r_state    <= S_LOW;
                            end else begin
                                r_rx_data  <= r_rx_shift;
                                r_rx_valid <= 1'b1;
                                r_byte_cnt <= r_byte_cnt + 16'd1;
                                r_state    <= (r_byte_cnt == LAST_BYTE) ? S_HOLD : S_LOAD;
                            end
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (w_div_end) begin
                            r_ssel  <= 1'b1;
                            r_div   <= '0;
                            r_state <= S_DEASS;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    S_DEASS: begin
                        if (w_div_end) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    S_ABORT: begin
                        // Same deassert hold as a normal end, but no done pulse
                        if (w_div_end) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
